pixel_stream_out: RTL
=====================

// Module: pixel_stream_out
// PURPOSE
// Downstream stage of the pixel pipeline top level. Samples the per-clock line/column/RGB output,
// keeps only the active area, and buffers pixels in a first-word-fall-through FIFO.
// Streams them out on a valid/ready interface with start-of-frame and end-of-line tags.
// The sink is the capture/serializer path.
// On FIFO overflow it drops the rest of the frame, so the sink never sees a torn frame.
// PARAMETERS
// ACTIVE_W    512  active pixels per line; columns >= ACTIVE_W are ignored
// ACTIVE_H    480  active lines per frame; lines >= ACTIVE_H are ignored
// FIFO_DEPTH  64   FIFO entries; power of two, >= 4
// PORTS
// clk             in   1   pixel clock; one line/column position per cycle
// reset           in   1   asynchronous, active-low reset
// line            in   10  current scan line from the VGA timing core
// column          in   10  current scan column from the VGA timing core
// r_in,g_in,b_in  in   8   pixel colour, valid in the same cycle as line/column
// enable          in   1   stream request; acted on only at frame boundaries
// m_valid         out  1   m_data/m_sof/m_eol hold a pixel
// m_ready         in   1   sink accepts the pixel when m_valid && m_ready
// m_data          out  24  {r,g,b}
// m_sof           out  1   pixel is line 0, column 0
// m_eol           out  1   pixel is column ACTIVE_W-1
// fifo_level      out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// drop_count      out  16  frames aborted due to overflow; saturates at 16'hFFFF
// streaming       out  1   high while in state STREAM
// BEHAVIOUR
// - Reset, asynchronous while reset==0:
//   - state=IDLE; FIFO empty; m_valid=0; m_data/m_sof/m_eol=0.
//   - fifo_level=0; drop_count=0; streaming=0.
// - Definitions:
//   - active = (column<ACTIVE_W) && (line<ACTIVE_H).
//   - sof_pos = (line==0) && (column==0).
//   - pop = m_valid && m_ready.
// - Capture word is {r_in,g_in,b_in, sof_pos, column==ACTIVE_W-1}, taken in a single cycle.
// - State machine, evaluated at each clk edge:
//   - IDLE:
//     - Waits for sof_pos && enable, then goes to STREAM.
//     - The sof pixel itself is pushed in that same cycle.
//   - STREAM:
//     - Each active cycle pushes one word.
//     - At sof_pos with enable==0: go to IDLE; nothing is pushed.
//     - Push with the FIFO full and no pop in the same cycle is an overflow:
//       - the word is discarded;
//       - drop_count increments (saturating);
//       - state goes to DROP.
//   - DROP:
//     - Discards everything.
//     - At sof_pos, goes to STREAM if enable==1 (pushing sof), else to IDLE.
// - FIFO rules:
//   - Full is FIFO_DEPTH entries.
//   - A simultaneous push and pop when full is accepted; fifo_level is unchanged.
//   - A pop when empty is impossible, because m_valid=0.
//   - Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.
// - Latency and output stability:
//   - A word pushed at edge N into an empty FIFO shows m_valid=1 after edge N (registered, FWFT).
//   - m_data/m_sof/m_eol stay stable while m_valid && !m_ready.
// - Entering DROP or IDLE does not flush the FIFO; already-buffered pixels of the aborted frame still drain.
//   - The sink detects the abort by a new m_sof arriving before ACTIVE_H m_eol tags.
// - Blanking (!active) cycles never push, in any state.
// - The sink may hold m_ready low indefinitely; this only causes overflow/DROP, never a lockup.
// - Reset mid-frame: everything clears immediately and the block restarts in IDLE.
//   - Streaming resumes only at the next sof_pos.
// TESTING
// 1. enable=1, m_ready=1, ACTIVE_W=8, ACTIVE_H=4 sweep:
//    -> 32 words in raster order, first m_sof=1, m_eol on every 8th; drop_count=0.
// 2. enable raised mid-frame at line 2:
//    -> no output until next line0/col0; first word then has m_sof=1.
// 3. m_ready=0 for a whole frame, FIFO_DEPTH=8:
//    -> fifo_level reaches 8; drop_count=1; state DROP.
//    -> After m_ready=1: exactly 8 words drain; the next frame streams complete.
// 4. FIFO full, push and pop in the same cycle:
//    -> word accepted, fifo_level stays 8, no drop.
// 5. enable dropped mid-frame:
//    -> current frame completes; IDLE at next sof; streaming=0.
// 6. reset pulsed low mid-line with 5 entries buffered:
//    -> m_valid=0, fifo_level=0 immediately (async); no output until the next sof.

Source files
------------

// File: rtl/pixel_stream_out.sv
// Active-area pixel capture into a first-word-fall-through FIFO, streamed out on valid/ready.
// A FIFO overflow abandons the rest of the frame until the next start-of-frame.
module pixel_stream_out #(
  parameter int ACTIVE_W   = 512,
  parameter int ACTIVE_H   = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    line,
  input  logic [9:0]                    column,
  input  logic [7:0]                    r_in,
  input  logic [7:0]                    g_in,
  input  logic [7:0]                    b_in,
  input  logic                          enable,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [23:0]                   m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic                          streaming
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [9:0]    COL_LIM  = 10'(ACTIVE_W);
  localparam logic [9:0]    LINE_LIM = 10'(ACTIVE_H);
  localparam logic [9:0]    EOL_COL  = 10'(ACTIVE_W - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DROP} state_t;

  state_t        state, state_nxt;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [25:0]   word_in, head;
  logic          active, sof_pos, full, pop, want, push, overflow;

  assign active   = (column < COL_LIM) && (line < LINE_LIM);
  assign sof_pos  = (line == '0) && (column == '0);
  assign word_in  = {r_in, g_in, b_in, sof_pos, column == EOL_COL};
  assign full     = (count == FULL_LVL);
  assign m_valid  = (count != '0);
  assign pop      = m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    want      = 1'b0;
    case (state)
      IDLE: begin
        if (sof_pos && enable) begin
          state_nxt = STREAM;
          want      = 1'b1;
        end
      end
      STREAM: begin
        if (sof_pos && !enable) state_nxt = IDLE;
        else if (active)        want      = 1'b1;
      end
      DROP: begin
        if (sof_pos) begin
          if (enable) begin
            state_nxt = STREAM;
            want      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    overflow = want && full && !pop;
    push     = want && !overflow;
    if (overflow) state_nxt = DROP;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Outputs are forced to zero while empty so reset shows clean data without resetting the array.
  assign head       = m_valid ? mem[rd_ptr] : '0;
  assign m_data     = head[25:2];
  assign m_sof      = head[1];
  assign m_eol      = head[0];
  assign fifo_level = count;
  assign streaming  = (state == STREAM);

endmodule
